// File: rtl/fifo_sum_ctrl_p.sv
// fifo_sum_ctrl_p
// Windowed column-sum controller between a UART receiver and a UART
// transmitter. Bytes of a ROW x COL frame arrive one per valid_flag rising
// edge. The previous WIN-1 rows are kept in per-column line buffers. From row
// WIN-1 onward, each byte is added to the elements directly above it. The sum
// is saturated or truncated to DATA_W, queued in an output FIFO and handed to
// the transmitter one byte at a time.
//
// Ports:
//   sys_clk     system clock
//   rst         asynchronous reset, active-high
//   clr         synchronous frame abort (counters, line buffers, output FIFO, ovf)
//   rx_data     received byte, stable while valid_flag is high
//   valid_flag  receive-valid level, one byte per rising edge
//   tx_ready    transmitter idle
//   tx_data     byte to transmit, valid while tx_en is high (0 otherwise)
//   tx_en       one-cycle transmit strobe; the FIFO head pops on the same edge
//   frame_done  one-cycle pulse with the write (or drop) of a frame's last sum
//   ovf         sticky, a sum was dropped because the output FIFO was full
module fifo_sum_ctrl_p #(
   parameter int DATA_W    = 8,
   parameter int ROW       = 4,
   parameter int COL       = 5,
   parameter int WIN       = 3,
   parameter int SAT_EN    = 1,
   parameter int OUT_DEPTH = 8
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              clr,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              valid_flag,
   input  logic              tx_ready,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_en,
   output logic              frame_done,
   output logic              ovf
);

   localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;
   localparam int CW = (COL > 1) ? $clog2(COL) : 1;
   localparam int AW = $clog2(OUT_DEPTH);
   localparam int SW = DATA_W + 2;

   localparam logic [RW-1:0] ROW_LAST  = RW'(ROW - 1);
   localparam logic [RW-1:0] ROW_FIRST = RW'(WIN - 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(COL - 1);

   logic              valid_d1;
   logic              valid_d2;
   logic              rise_q;
   logic              accept;
   logic              frame_last;
   logic              row_out;
   logic [RW-1:0]     row_cnt;
   logic [CW-1:0]     col_cnt;
   logic [DATA_W-1:0] line_mem [WIN-1][COL];
   logic [SW-1:0]     sum_full;
   logic [DATA_W-1:0] result;
   logic              wr_valid;
   logic [DATA_W-1:0] wr_data;
   logic              frame_done_q;
   logic [DATA_W-1:0] out_mem [OUT_DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic              fifo_empty;
   logic              fifo_full;
   logic              do_write;
   logic              drop;
   logic              tx_en_q;
   logic              ovf_q;

   // Two-stage synchroniser on valid_flag followed by a registered rising-edge
   // detector. The registered rise marks the single accept cycle of a byte, so
   // holding valid_flag high cannot produce a second accept. clr leaves these
   // alone so a level still held across an abort is not re-accepted.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         valid_d1 <= 1'b0;
         valid_d2 <= 1'b0;
         rise_q   <= 1'b0;
      end else begin
         valid_d1 <= valid_flag;
         valid_d2 <= valid_d1;
         rise_q   <= valid_d1 & ~valid_d2;
      end
   end

   assign accept     = rise_q & ~clr;
   assign frame_last = (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);
   assign row_out    = (row_cnt >= ROW_FIRST);

   // Row/column position and the line buffers. Every line is addressed by the
   // current column: reading slot col_cnt yields the element one row up (line
   // 0), two rows up (line 1) and so on. Writing the slot back shifts the
   // column down one line, which is the chained push/pop of full line FIFOs.
   // The last byte of a frame flushes every line so frames never mix.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         row_cnt <= '0;
         col_cnt <= '0;
         for (int k = 0; k < WIN - 1; k++)
            for (int i = 0; i < COL; i++)
               line_mem[k][i] <= '0;
      end else if (clr) begin
         row_cnt <= '0;
         col_cnt <= '0;
         for (int k = 0; k < WIN - 1; k++)
            for (int i = 0; i < COL; i++)
               line_mem[k][i] <= '0;
      end else if (accept) begin
         if (frame_last) begin
            row_cnt <= '0;
            col_cnt <= '0;
            for (int k = 0; k < WIN - 1; k++)
               for (int i = 0; i < COL; i++)
                  line_mem[k][i] <= '0;
         end else begin
            if (col_cnt == COL_LAST) begin
               col_cnt <= '0;
               row_cnt <= row_cnt + RW'(1);
            end else begin
               col_cnt <= col_cnt + CW'(1);
            end
            line_mem[0][col_cnt] <= rx_data;
            for (int k = 1; k < WIN - 1; k++)
               line_mem[k][col_cnt] <= line_mem[k-1][col_cnt];
         end
      end
   end

   // Window sum over the incoming byte and the line outputs. Two guard bits
   // are enough for up to four DATA_W operands.
   always_comb begin
      sum_full = SW'(rx_data);
      for (int k = 0; k < WIN - 1; k++)
         sum_full = sum_full + SW'(line_mem[k][col_cnt]);
   end

   // Clamp to all-ones when saturating, otherwise keep the low DATA_W bits.
   always_comb begin
      result = sum_full[DATA_W-1:0];
      if ((SAT_EN != 0) && (sum_full[SW-1:DATA_W] != 2'b00))
         result = '1;
   end

   // One-cycle write stage. The sum is offered to the output FIFO in the
   // cycle after the accept, and frame_done is aligned with that write.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         wr_valid     <= 1'b0;
         wr_data      <= '0;
         frame_done_q <= 1'b0;
      end else if (clr) begin
         wr_valid     <= 1'b0;
         wr_data      <= '0;
         frame_done_q <= 1'b0;
      end else begin
         wr_valid     <= accept & row_out;
         wr_data      <= result;
         frame_done_q <= accept & frame_last;
      end
   end

   assign frame_done = frame_done_q;

   // Output FIFO status. The pointers carry one extra wrap bit to tell full
   // from empty. A pop in the same cycle frees a slot for the write.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign tx_en      = ~clr & ~fifo_empty & tx_ready & ~tx_en_q;
   assign do_write   = wr_valid & (~fifo_full | tx_en);
   assign drop       = wr_valid & fifo_full & ~tx_en;
   assign tx_data    = tx_en ? out_mem[rd_ptr[AW-1:0]] : '0;
   assign ovf        = ovf_q;

   // Output FIFO storage and the transmit handshake. tx_en_q blocks
   // back-to-back strobes so the transmitter has a cycle to drop tx_ready.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         tx_en_q <= 1'b0;
         ovf_q   <= 1'b0;
         for (int i = 0; i < OUT_DEPTH; i++)
            out_mem[i] <= '0;
      end else if (clr) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         tx_en_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (do_write) begin
            out_mem[wr_ptr[AW-1:0]] <= wr_data;
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (tx_en)
            rd_ptr <= rd_ptr + (AW+1)'(1);
         if (drop)
            ovf_q <= 1'b1;
         tx_en_q <= tx_en;
      end
   end

endmodule

// File: tb/tb_fifo_sum_ctrl_p.sv
// tb_fifo_sum_ctrl_p
// Drives two copies of fifo_sum_ctrl_p with shared stimulus, one saturating
// and one truncating. Expected transmit bytes come from a frame-level model
// that indexes a stored frame by row and column.
module tb_fifo_sum_ctrl_p;

   localparam int DATA_W    = 8;
   localparam int ROW       = 4;
   localparam int COL       = 5;
   localparam int WIN       = 3;
   localparam int OUT_DEPTH = 8;
   localparam int NBYTES    = ROW * COL;

   logic              sys_clk = 1'b0;
   logic              rst;
   logic              clr;
   logic [DATA_W-1:0] rx_data;
   logic              valid_flag;
   logic              ready_level;
   logic              hs_mode;
   logic              hs_ready;
   logic              tx_ready;
   logic [DATA_W-1:0] tx_data;
   logic              tx_en;
   logic              frame_done;
   logic              ovf;
   logic [DATA_W-1:0] tx_data_t;
   logic              tx_en_t;
   logic              frame_done_t;
   logic              ovf_t;

   int checks = 0;
   int errors = 0;
   int exp_sat[$];
   int exp_trn[$];
   int obs_sat[$];
   int obs_trn[$];
   int frame_bytes[NBYTES];
   int model_idx     = 0;
   int model_frames  = 0;
   int model_pending = 0;
   bit model_hold    = 1'b0;
   bit model_ovf     = 1'b0;
   int fd_count      = 0;
   int fd_count_t    = 0;
   int since_en      = 1000;
   bit saw_en        = 1'b0;
   int hold_cnt      = 0;

   assign tx_ready = hs_mode ? hs_ready : ready_level;

   always #5 sys_clk = ~sys_clk;

   fifo_sum_ctrl_p #(.DATA_W(DATA_W), .ROW(ROW), .COL(COL), .WIN(WIN),
                     .SAT_EN(1), .OUT_DEPTH(OUT_DEPTH)) u_dut (
      .sys_clk(sys_clk), .rst(rst), .clr(clr), .rx_data(rx_data),
      .valid_flag(valid_flag), .tx_ready(tx_ready), .tx_data(tx_data),
      .tx_en(tx_en), .frame_done(frame_done), .ovf(ovf));

   fifo_sum_ctrl_p #(.DATA_W(DATA_W), .ROW(ROW), .COL(COL), .WIN(WIN),
                     .SAT_EN(0), .OUT_DEPTH(OUT_DEPTH)) u_trunc (
      .sys_clk(sys_clk), .rst(rst), .clr(clr), .rx_data(rx_data),
      .valid_flag(valid_flag), .tx_ready(tx_ready), .tx_data(tx_data_t),
      .tx_en(tx_en_t), .frame_done(frame_done_t), .ovf(ovf_t));

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Collect transmitted bytes and frame_done pulses on the falling edge, and
   // check strobe spacing while the slow transmitter model is active.
   always @(negedge sys_clk) begin
      if (tx_en === 1'b1) begin
         obs_sat.push_back(int'(tx_data));
         if (hs_mode)
            checkOutput("hs_spacing_ge_11", 32'(since_en + 1 >= 11), 32'd1);
         since_en = 0;
      end else if (since_en < 1000) begin
         since_en++;
      end
      saw_en = (tx_en === 1'b1);
      if (tx_en_t === 1'b1)
         obs_trn.push_back(int'(tx_data_t));
      if (frame_done === 1'b1)
         fd_count++;
      if (frame_done_t === 1'b1)
         fd_count_t++;
   end

   // Slow transmitter: busy for 10 cycles after every strobe.
   initial begin
      hs_ready = 1'b1;
      forever begin
         @(posedge sys_clk);
         #1;
         if (hs_mode) begin
            if (saw_en) begin
               hs_ready = 1'b0;
               hold_cnt = 10;
            end else if (hold_cnt > 0) begin
               hold_cnt--;
               if (hold_cnt == 0)
                  hs_ready = 1'b1;
            end
         end else begin
            hs_ready = 1'b1;
            hold_cnt = 0;
         end
      end
   end

   // Frame model: store the byte at its frame position; from row WIN-1 on,
   // the expected output is the sum of the column's last WIN entries.
   task automatic modelPush(input int b);
      int r;
      int c;
      int s;
      frame_bytes[model_idx] = b;
      r = model_idx / COL;
      c = model_idx % COL;
      if (r >= WIN - 1) begin
         s = 0;
         for (int k = 0; k < WIN; k++)
            s += frame_bytes[(r - k) * COL + c];
         if (model_hold && model_pending >= OUT_DEPTH) begin
            model_ovf = 1'b1;
         end else begin
            exp_sat.push_back(s > 255 ? 255 : s);
            exp_trn.push_back(s % 256);
            if (model_hold)
               model_pending++;
         end
      end
      model_idx++;
      if (model_idx == NBYTES) begin
         model_idx = 0;
         model_frames++;
      end
   endtask

   task automatic applyStimulus(input int b, input int hold);
      @(negedge sys_clk);
      rx_data    = b[DATA_W-1:0];
      valid_flag = 1'b1;
      modelPush(b);
      repeat (hold) @(negedge sys_clk);
      valid_flag = 1'b0;
      repeat (2 + $urandom_range(0, 3)) @(negedge sys_clk);
   endtask

   task automatic clearQueues();
      exp_sat.delete();
      exp_trn.delete();
      obs_sat.delete();
      obs_trn.delete();
   endtask

   task automatic drainCompare(input string tag);
      int t;
      int n;
      t = 0;
      while ((obs_sat.size() < exp_sat.size() || obs_trn.size() < exp_trn.size())
             && t < 3000) begin
         @(negedge sys_clk);
         t++;
      end
      repeat (6) @(negedge sys_clk);
      checkOutput($sformatf("%s_sat_len", tag), obs_sat.size(), exp_sat.size());
      checkOutput($sformatf("%s_trn_len", tag), obs_trn.size(), exp_trn.size());
      n = (obs_sat.size() < exp_sat.size()) ? obs_sat.size() : exp_sat.size();
      for (int i = 0; i < n; i++)
         checkOutput($sformatf("%s_sat_%0d", tag, i), obs_sat[i], exp_sat[i]);
      n = (obs_trn.size() < exp_trn.size()) ? obs_trn.size() : exp_trn.size();
      for (int i = 0; i < n; i++)
         checkOutput($sformatf("%s_trn_%0d", tag, i), obs_trn[i], exp_trn[i]);
      clearQueues();
   endtask

   task automatic randomFrame(input int count);
      for (int i = 0; i < count; i++)
         applyStimulus($urandom_range(0, 255), 4);
   endtask

   initial begin
      int b;
      rst         = 1'b1;
      clr         = 1'b0;
      valid_flag  = 1'b0;
      rx_data     = '0;
      ready_level = 1'b1;
      hs_mode     = 1'b0;

      // Reset state
      repeat (3) @(negedge sys_clk);
      checkOutput("rst_tx_en", tx_en, 0);
      checkOutput("rst_tx_data", tx_data, 0);
      checkOutput("rst_frame_done", frame_done, 0);
      checkOutput("rst_ovf", ovf, 0);
      rst = 1'b0;
      @(negedge sys_clk);
      checkOutput("idle_tx_en", tx_en, 0);

      // Sequential bytes 1..20
      for (int i = 1; i <= NBYTES; i++)
         applyStimulus(i, 4);
      drainCompare("seq");
      checkOutput("seq_frame_done", fd_count, model_frames);
      checkOutput("seq_frame_done_t", fd_count_t, model_frames);

      // Saturation vs truncation with all-ones bytes
      for (int i = 0; i < NBYTES; i++)
         applyStimulus(255, 4);
      drainCompare("sat");

      // Two back-to-back random frames
      randomFrame(2 * NBYTES);
      drainCompare("rand2");
      checkOutput("rand2_frame_done", fd_count, model_frames);

      // Latency of the first output byte, then a long-held valid level
      randomFrame(2 * COL);
      drainCompare("lat_pre");
      @(negedge sys_clk);
      b = $urandom_range(0, 255);
      rx_data    = b[DATA_W-1:0];
      valid_flag = 1'b1;
      modelPush(b);
      for (int i = 1; i <= 5; i++) begin
         @(negedge sys_clk);
         checkOutput($sformatf("latency_%0d", i), tx_en, 32'(i == 4));
      end
      valid_flag = 1'b0;
      repeat (3) @(negedge sys_clk);
      applyStimulus($urandom_range(0, 255), 50);
      drainCompare("held");
      randomFrame(NBYTES - 2 * COL - 2);
      drainCompare("lat_rest");

      // Slow transmitter handshake
      hs_mode = 1'b1;
      randomFrame(NBYTES);
      drainCompare("hs");
      hs_mode = 1'b0;
      repeat (3) @(negedge sys_clk);

      // Overflow with the transmitter held busy
      ready_level   = 1'b0;
      model_hold    = 1'b1;
      model_pending = 0;
      randomFrame(NBYTES - 2);
      checkOutput("ovf_before_9th", ovf, model_ovf);
      randomFrame(1);
      checkOutput("ovf_after_9th", ovf, model_ovf);
      randomFrame(1);
      checkOutput("ovf_trunc", ovf_t, model_ovf);
      ready_level = 1'b1;
      model_hold  = 1'b0;
      drainCompare("ovf_drain");
      checkOutput("ovf_sticky", ovf, model_ovf);

      // Abort mid-frame, then a clean frame of 1..20
      randomFrame(7);
      @(negedge sys_clk);
      clr = 1'b1;
      @(negedge sys_clk);
      clr = 1'b0;
      model_idx = 0;
      model_ovf = 1'b0;
      checkOutput("clr_ovf", ovf, model_ovf);
      for (int i = 1; i <= NBYTES; i++)
         applyStimulus(i, 4);
      drainCompare("after_clr");
      checkOutput("clr_frame_done", fd_count, model_frames);

      // Asynchronous reset while a byte is being offered
      ready_level   = 1'b0;
      model_hold    = 1'b1;
      model_pending = 0;
      randomFrame(12);
      repeat (3) @(negedge sys_clk);
      @(posedge sys_clk);
      #2;
      ready_level = 1'b1;
      #1;
      checkOutput("pre_rst_tx_en", tx_en, 1);
      checkOutput("pre_rst_tx_data", tx_data, exp_sat[0]);
      rst = 1'b1;
      #1;
      checkOutput("async_rst_tx_en", tx_en, 0);
      checkOutput("async_rst_tx_data", tx_data, 0);
      checkOutput("async_rst_frame_done", frame_done, 0);
      checkOutput("async_rst_ovf", ovf, 0);
      @(negedge sys_clk);
      @(negedge sys_clk);
      rst = 1'b0;
      clearQueues();
      model_idx  = 0;
      model_hold = 1'b0;
      model_ovf  = 1'b0;
      randomFrame(NBYTES);
      drainCompare("after_rst");
      checkOutput("rst_frame_done_total", fd_count, model_frames);
      checkOutput("rst_frame_done_total_t", fd_count_t, model_frames);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
